// File: rtl/decap_ekey_lookup_if.sv
// Request/result handshake bundle between the decap pipeline and the ekey lookup engine.
// The master is the pipeline side; the slave is the lookup engine.
interface decap_ekey_lookup_if #(
  parameter int DEPTH_NBITS       = 10,
  parameter int KEY_NBITS         = 32,
  parameter int VALUE_DEPTH_NBITS = 12,
  parameter int VALUE_NBITS       = 128
);
  logic                         lookup_valid;
  logic                         lookup_ready;
  logic [KEY_NBITS-1:0]         lookup_key;
  logic [DEPTH_NBITS-1:0]       lookup_hash0;
  logic [DEPTH_NBITS-1:0]       lookup_hash1;
  logic                         result_valid;
  logic                         result_ready;
  logic                         result_hit;
  logic [VALUE_DEPTH_NBITS-1:0] result_ptr;
  logic [VALUE_NBITS-1:0]       result_value;

  modport master (
    output lookup_valid, lookup_key, lookup_hash0, lookup_hash1, result_ready,
    input  lookup_ready, result_valid, result_hit, result_ptr, result_value
  );

  modport slave (
    input  lookup_valid, lookup_key, lookup_hash0, lookup_hash1, result_ready,
    output lookup_ready, result_valid, result_hit, result_ptr, result_value
  );
endinterface

// File: rtl/decap_ekey_lookup.sv
// Ekey lookup engine: reads two hash buckets in parallel, matches the key, fetches the
// value record on a hit and returns one hit/miss result per request with saturating stats.
module decap_ekey_lookup #(
  parameter int DEPTH_NBITS       = 10,
  parameter int ENTRIES           = 4,
  parameter int KEY_NBITS         = 32,
  parameter int VALUE_DEPTH_NBITS = 12,
  parameter int BUCKET_NBITS      = ENTRIES * (1 + KEY_NBITS + VALUE_DEPTH_NBITS),
  parameter int VALUE_NBITS       = 128,
  parameter int CNT_NBITS         = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  decap_ekey_lookup_if.slave           lk,
  output logic                         ekey_hash_table0_rd,
  output logic [DEPTH_NBITS-1:0]       ekey_hash_table0_raddr,
  input  logic                         ekey_hash_table0_ack,
  input  logic [BUCKET_NBITS-1:0]      ekey_hash_table0_rdata,
  output logic                         ekey_hash_table1_rd,
  output logic [DEPTH_NBITS-1:0]       ekey_hash_table1_raddr,
  input  logic                         ekey_hash_table1_ack,
  input  logic [BUCKET_NBITS-1:0]      ekey_hash_table1_rdata,
  output logic                         ekey_value_rd,
  output logic [VALUE_DEPTH_NBITS-1:0] ekey_value_raddr,
  input  logic                         ekey_value_ack,
  input  logic [VALUE_NBITS-1:0]       ekey_value_rdata,
  output logic [CNT_NBITS-1:0]         hit_cnt,
  output logic [CNT_NBITS-1:0]         miss_cnt
);
  localparam int ENTRY_NBITS = 1 + KEY_NBITS + VALUE_DEPTH_NBITS;

  typedef enum logic [1:0] {IDLE, WAIT_BKT, WAIT_VAL, RESULT} state_t;

  state_t                       state, state_nxt;
  logic [KEY_NBITS-1:0]         key_q;
  logic [BUCKET_NBITS-1:0]      bkt0_q, bkt1_q, bkt0_cur, bkt1_cur;
  logic                         done0, done1, take0, take1, both_done;
  logic                         accept, match_hit;
  logic [VALUE_DEPTH_NBITS-1:0] match_ptr;
  logic [ENTRY_NBITS-1:0]       entry;
  logic                         res_hit;
  logic [VALUE_DEPTH_NBITS-1:0] res_ptr;
  logic [VALUE_NBITS-1:0]       res_value;

  // Only the first ack of each table in WAIT_BKT is taken; repeats and strays are dropped.
  assign take0     = (state == WAIT_BKT) && ekey_hash_table0_ack && !done0;
  assign take1     = (state == WAIT_BKT) && ekey_hash_table1_ack && !done1;
  assign bkt0_cur  = take0 ? ekey_hash_table0_rdata : bkt0_q;
  assign bkt1_cur  = take1 ? ekey_hash_table1_rdata : bkt1_q;
  assign both_done = (done0 || take0) && (done1 || take1);

  assign lk.lookup_ready = (state == IDLE);
  assign lk.result_valid = (state == RESULT);
  assign lk.result_hit   = res_hit;
  assign lk.result_ptr   = res_ptr;
  assign lk.result_value = res_value;

  // Scan from lowest priority to highest so the last hit written wins (table 0, entry 0 first).
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    match_hit = 1'b0;
    match_ptr = '0;
    entry     = '0;
    for (int t = 1; t >= 0; t--) begin
      for (int i = ENTRIES - 1; i >= 0; i--) begin
        entry = (t == 0) ? bkt0_cur[i*ENTRY_NBITS +: ENTRY_NBITS]
                         : bkt1_cur[i*ENTRY_NBITS +: ENTRY_NBITS];
        if (entry[ENTRY_NBITS-1] && (entry[VALUE_DEPTH_NBITS +: KEY_NBITS] == key_q)) begin
          match_hit = 1'b1;
          match_ptr = entry[VALUE_DEPTH_NBITS-1:0];
        end
      end
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    unique case (state)
      IDLE:     if (lk.lookup_valid) begin
                  accept    = 1'b1;
                  state_nxt = WAIT_BKT;
                end
      WAIT_BKT: if (both_done) state_nxt = match_hit ? WAIT_VAL : RESULT;
      WAIT_VAL: if (ekey_value_ack) state_nxt = RESULT;
      RESULT:   if (lk.result_ready) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the bucket holding registers are reset too, so a reset mid-lookup leaves no stale data.
      key_q                  <= '0;
      bkt0_q                 <= '0;
      bkt1_q                 <= '0;
      done0                  <= 1'b0;
      done1                  <= 1'b0;
      ekey_hash_table0_rd    <= 1'b0;
      ekey_hash_table1_rd    <= 1'b0;
      ekey_hash_table0_raddr <= '0;
      ekey_hash_table1_raddr <= '0;
      ekey_value_rd          <= 1'b0;
      ekey_value_raddr       <= '0;
      res_hit                <= 1'b0;
      res_ptr                <= '0;
      res_value              <= '0;
      hit_cnt                <= '0;
      miss_cnt               <= '0;
    end else begin
      ekey_hash_table0_rd <= 1'b0;
      ekey_hash_table1_rd <= 1'b0;
      ekey_value_rd       <= 1'b0;
      if (accept) begin
        key_q                  <= lk.lookup_key;
        ekey_hash_table0_raddr <= lk.lookup_hash0;
        ekey_hash_table1_raddr <= lk.lookup_hash1;
        ekey_hash_table0_rd    <= 1'b1;
        ekey_hash_table1_rd    <= 1'b1;
        done0                  <= 1'b0;
        done1                  <= 1'b0;
      end
      if (take0) begin
        bkt0_q <= ekey_hash_table0_rdata;
        done0  <= 1'b1;
      end
      if (take1) begin
        bkt1_q <= ekey_hash_table1_rdata;
        done1  <= 1'b1;
      end
      if ((state == WAIT_BKT) && both_done) begin
        if (match_hit) begin
          ekey_value_rd    <= 1'b1;
          ekey_value_raddr <= match_ptr;
          res_ptr          <= match_ptr;
        end else begin
          res_hit   <= 1'b0;
          res_ptr   <= '0;
          res_value <= '0;
        end
      end
      if ((state == WAIT_VAL) && ekey_value_ack) begin
        res_value <= ekey_value_rdata;
        res_hit   <= 1'b1;
      end
      if ((state == RESULT) && lk.result_ready) begin
        if (res_hit) begin
          if (hit_cnt != '1) hit_cnt <= hit_cnt + CNT_NBITS'(1);
        end else begin
          if (miss_cnt != '1) miss_cnt <= miss_cnt + CNT_NBITS'(1);
        end
      end
    end
  end
endmodule
